ex_mem_reg: RTL and testbench

//   EX->MEM pipeline register of the P7 MIPS core. Captures the E-stage ALU

---
 rtl/core_defs.sv | 39 +++
 rtl/ex_mem_reg_exc_merge.sv | 40 ++++
 rtl/ex_mem_reg.sv | 117 +++++++++++
 tb/tb_ex_mem_reg.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_defs.sv
// ---------------------------------------------------------------------------
// core_defs
//   Shared definitions for the P7 MIPS pipeline registers: exception codes,
//   architectural PC constants and the M-stage register bundle.
// ---------------------------------------------------------------------------
package core_defs;

  // Exception codes as seen in CP0 Cause.ExcCode
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // PC seen by the M stage after reset and after an exception flush
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // Everything the EX->MEM register carries into the M stage
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        reg_write;
    logic        mem_write;
    logic        load;
    logic        bd;
    logic [4:0]  exc_code;
  } m_stage_t;

  // Earlier pipeline stages report first, so their code wins over a later one
  function automatic logic [4:0] merge_exc(input logic [4:0] early,
                                           input logic [4:0] late);
    return (early != EXC_NONE) ? early : late;
  endfunction

endpackage

// File: rtl/ex_mem_reg_exc_merge.sv
// ---------------------------------------------------------------------------
// exc_merge
//   Combinational exception merge and architectural-write squash, shared by
//   the EX->MEM and MEM->WB registers.
// Ports:
//   exc_in        in  5  code carried from earlier stages
//   exc_stage     in  5  code raised by the current stage
//   reg_write     in  1  raw GPR write enable
//   mem_write     in  1  raw store enable
//   a3            in  5  raw destination GPR
//   exc_code      out 5  merged code (earlier stage wins)
//   reg_write_g   out 1  write enable, cleared when an exception is present
//   mem_write_g   out 1  store enable, cleared when an exception is present
//   a3_g          out 5  destination, zeroed when an exception is present
// ---------------------------------------------------------------------------
module exc_merge
  import core_defs::*;
(
  input  logic [4:0] exc_in,
  input  logic [4:0] exc_stage,
  input  logic       reg_write,
  input  logic       mem_write,
  input  logic [4:0] a3,
  output logic [4:0] exc_code,
  output logic       reg_write_g,
  output logic       mem_write_g,
  output logic [4:0] a3_g
);

  logic has_exc;

  assign exc_code = merge_exc(exc_in, exc_stage);
  assign has_exc  = (exc_code != EXC_NONE);

  // A faulting instruction must not change GPRs or memory
  assign reg_write_g = reg_write & ~has_exc;
  assign mem_write_g = mem_write & ~has_exc;
  assign a3_g        = has_exc ? 5'd0 : a3;

endmodule

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//   EX->MEM pipeline register of the P7 MIPS core. Captures the E-stage
//   results, control bits and merged exception state one cycle later.
//   Priority at each rising edge: Req (flush) > !en (hold) > load.
// Ports:
//   clk, rst_n                    clock (rising) / async active-low reset
//   Req                           CP0 exception request, inserts a bubble
//   en                            1 = load E values, 0 = hold
//   E_PC, E_Instr, E_ALUOut, E_WD 32-bit E-stage data
//   E_A3                          destination GPR
//   E_RegWrite, E_MemWrite        write enables
//   E_LOAD, E_BD                  load flag, branch-delay-slot flag
//   E_ExcIn                       exception code from F/D
//   ExcALU                        exception code from the ALU
//   M_*                           registered outputs, M_ExcCode merged code
// ---------------------------------------------------------------------------
module ex_mem_reg
  import core_defs::*;
#(
  parameter logic [31:0] RESET_PC   = core_defs::RESET_PC,
  parameter logic [31:0] HANDLER_PC = core_defs::HANDLER_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        en,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_ALUOut,
  input  logic [31:0] E_WD,
  input  logic [4:0]  E_A3,
  input  logic        E_RegWrite,
  input  logic        E_MemWrite,
  input  logic        E_LOAD,
  input  logic        E_BD,
  input  logic [4:0]  E_ExcIn,
  input  logic [4:0]  ExcALU,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic [31:0] M_ALUOut,
  output logic [31:0] M_WD,
  output logic [4:0]  M_A3,
  output logic        M_RegWrite,
  output logic        M_MemWrite,
  output logic        M_LOAD,
  output logic        M_BD,
  output logic [4:0]  M_ExcCode
);

  m_stage_t   m_q;
  m_stage_t   load_val;
  m_stage_t   bubble_val;
  m_stage_t   reset_val;

  logic [4:0] exc_code;
  logic       reg_write_g;
  logic       mem_write_g;
  logic [4:0] a3_g;

  exc_merge u_exc_merge (
    .exc_in      (E_ExcIn),
    .exc_stage   (ExcALU),
    .reg_write   (E_RegWrite),
    .mem_write   (E_MemWrite),
    .a3          (E_A3),
    .exc_code    (exc_code),
    .reg_write_g (reg_write_g),
    .mem_write_g (mem_write_g),
    .a3_g        (a3_g)
  );

  // ALU result is kept even on exceptions because it feeds BadVAddr
  always_comb begin
    load_val           = '0;
    load_val.pc        = E_PC;
    load_val.instr     = E_Instr;
    load_val.alu_out   = E_ALUOut;
    load_val.wd        = E_WD;
    load_val.a3        = a3_g;
    load_val.reg_write = reg_write_g;
    load_val.mem_write = mem_write_g;
    load_val.load      = E_LOAD;
    load_val.bd        = E_BD;
    load_val.exc_code  = exc_code;
  end

  // A flushed slot still shows the handler PC so the macroscopic PC stays valid
  always_comb begin
    bubble_val    = '0;
    bubble_val.pc = HANDLER_PC;
    reset_val     = '0;
    reset_val.pc  = RESET_PC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= reset_val;
    end else if (Req) begin
      m_q <= bubble_val;
    end else if (en) begin
      m_q <= load_val;
    end
  end

  assign M_PC       = m_q.pc;
  assign M_Instr    = m_q.instr;
  assign M_ALUOut   = m_q.alu_out;
  assign M_WD       = m_q.wd;
  assign M_A3       = m_q.a3;
  assign M_RegWrite = m_q.reg_write;
  assign M_MemWrite = m_q.mem_write;
  assign M_LOAD     = m_q.load;
  assign M_BD       = m_q.bd;
  assign M_ExcCode  = m_q.exc_code;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
//   Self-checking bench for ex_mem_reg. Expected M-stage contents are pushed
//   onto a queue when stimulus is applied and popped after the capturing edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        reg_write;
    logic        mem_write;
    logic        load;
    logic        bd;
    logic [4:0]  exc;
  } out_t;

  typedef struct packed {
    logic        req;
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        reg_write;
    logic        mem_write;
    logic        load;
    logic        bd;
    logic [4:0]  exc_in;
    logic [4:0]  exc_alu;
  } in_t;

  localparam out_t RST_OUT = '{pc: 32'h0000_3000, default: '0};
  localparam out_t BUB_OUT = '{pc: 32'h0000_4180, default: '0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Req = 1'b0;
  logic        en = 1'b0;
  logic [31:0] E_PC = '0;
  logic [31:0] E_Instr = '0;
  logic [31:0] E_ALUOut = '0;
  logic [31:0] E_WD = '0;
  logic [4:0]  E_A3 = '0;
  logic        E_RegWrite = 1'b0;
  logic        E_MemWrite = 1'b0;
  logic        E_LOAD = 1'b0;
  logic        E_BD = 1'b0;
  logic [4:0]  E_ExcIn = '0;
  logic [4:0]  ExcALU = '0;
  logic [31:0] M_PC;
  logic [31:0] M_Instr;
  logic [31:0] M_ALUOut;
  logic [31:0] M_WD;
  logic [4:0]  M_A3;
  logic        M_RegWrite;
  logic        M_MemWrite;
  logic        M_LOAD;
  logic        M_BD;
  logic [4:0]  M_ExcCode;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  out_t model_state;
  out_t observed;
  out_t expected;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Req        (Req),
    .en         (en),
    .E_PC       (E_PC),
    .E_Instr    (E_Instr),
    .E_ALUOut   (E_ALUOut),
    .E_WD       (E_WD),
    .E_A3       (E_A3),
    .E_RegWrite (E_RegWrite),
    .E_MemWrite (E_MemWrite),
    .E_LOAD     (E_LOAD),
    .E_BD       (E_BD),
    .E_ExcIn    (E_ExcIn),
    .ExcALU     (ExcALU),
    .M_PC       (M_PC),
    .M_Instr    (M_Instr),
    .M_ALUOut   (M_ALUOut),
    .M_WD       (M_WD),
    .M_A3       (M_A3),
    .M_RegWrite (M_RegWrite),
    .M_MemWrite (M_MemWrite),
    .M_LOAD     (M_LOAD),
    .M_BD       (M_BD),
    .M_ExcCode  (M_ExcCode)
  );

  assign observed = '{M_PC, M_Instr, M_ALUOut, M_WD, M_A3, M_RegWrite,
                      M_MemWrite, M_LOAD, M_BD, M_ExcCode};

  // Reference behaviour of one rising edge given the current register contents
  function automatic out_t model_edge(input in_t i, input out_t prev);
    out_t       o;
    logic [4:0] exc;
    if (i.req) return BUB_OUT;
    if (!i.en) return prev;
    exc         = (i.exc_in != 5'd0) ? i.exc_in : i.exc_alu;
    o.pc        = i.pc;
    o.instr     = i.instr;
    o.alu_out   = i.alu_out;
    o.wd        = i.wd;
    o.a3        = (exc != 5'd0) ? 5'd0 : i.a3;
    o.reg_write = (exc != 5'd0) ? 1'b0 : i.reg_write;
    o.mem_write = (exc != 5'd0) ? 1'b0 : i.mem_write;
    o.load      = i.load;
    o.bd        = i.bd;
    o.exc       = exc;
    return o;
  endfunction

  function automatic in_t random_in();
    in_t i;
    logic [4:0] codes [5];
    codes   = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    i.req       = ($urandom_range(0, 7) == 0);
    i.en        = ($urandom_range(0, 3) != 0);
    i.pc        = $urandom;
    i.instr     = $urandom;
    i.alu_out   = $urandom;
    i.wd        = $urandom;
    i.a3        = 5'($urandom);
    i.reg_write = 1'($urandom);
    i.mem_write = 1'($urandom);
    i.load      = 1'($urandom);
    i.bd        = 1'($urandom);
    i.exc_in    = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
    i.exc_alu   = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
    return i;
  endfunction

  task automatic apply_stimulus(input in_t i);
    Req        = i.req;
    en         = i.en;
    E_PC       = i.pc;
    E_Instr    = i.instr;
    E_ALUOut   = i.alu_out;
    E_WD       = i.wd;
    E_A3       = i.a3;
    E_RegWrite = i.reg_write;
    E_MemWrite = i.mem_write;
    E_LOAD     = i.load;
    E_BD       = i.bd;
    E_ExcIn    = i.exc_in;
    ExcALU     = i.exc_alu;
  endtask

  // Drive, record the expected result, advance to 1 time unit after the edge
  task automatic drive_and_step(input in_t i);
    apply_stimulus(i);
    model_state = model_edge(i, model_state);
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed !== RST_OUT) begin
      errors++;
      $display("[TB] FAIL reset_async got %h expected %h", observed, RST_OUT);
    end
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(random_in());
      @(posedge clk);
      #1;
      checks++;
      if (observed !== RST_OUT) begin
        errors++;
        $display("[TB] FAIL reset_edge%0d got %h expected %h", c, observed, RST_OUT);
      end
      #3;
      checks++;
      if (observed !== RST_OUT) begin
        errors++;
        $display("[TB] FAIL reset_mid%0d got %h expected %h", c, observed, RST_OUT);
      end
    end
    rst_n = 1'b1;
    model_state = RST_OUT;
  endtask

  task automatic test_normal_load();
    in_t i = '0;
    i.en = 1'b1; i.pc = 32'h3004; i.instr = 32'h2405_1234;
    i.alu_out = 32'h1234; i.wd = 32'hCAFE_0001; i.a3 = 5'd5; i.reg_write = 1'b1;
    drive_and_step(i);
    expected = '{32'h3004, 32'h2405_1234, 32'h1234, 32'hCAFE_0001, 5'd5,
                 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    checks++;
    if (observed !== exp_q.pop_front() || observed !== expected) begin
      errors++;
      $display("[TB] FAIL normal_load got %h expected %h", observed, expected);
    end
  endtask

  task automatic test_overflow();
    in_t i = '0;
    i.en = 1'b1; i.pc = 32'h3008; i.instr = 32'h0109_4020;
    i.alu_out = 32'h8000_0000; i.wd = 32'h11; i.a3 = 5'd8; i.reg_write = 1'b1;
    i.bd = 1'b1; i.exc_alu = 5'd12;
    drive_and_step(i);
    expected = '{32'h3008, 32'h0109_4020, 32'h8000_0000, 32'h11, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 5'd12};
    checks++;
    if (observed !== exp_q.pop_front() || observed !== expected) begin
      errors++;
      $display("[TB] FAIL overflow got %h expected %h", observed, expected);
    end
  endtask

  task automatic test_priority();
    in_t i = '0;
    i.en = 1'b1; i.pc = 32'h300C; i.instr = 32'hFC00_0000;
    i.alu_out = 32'h0000_1003; i.wd = 32'h55; i.a3 = 5'd3; i.mem_write = 1'b1;
    i.exc_in = 5'd10; i.exc_alu = 5'd5;
    drive_and_step(i);
    expected = '{32'h300C, 32'hFC00_0000, 32'h0000_1003, 32'h55, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd10};
    checks++;
    if (observed !== exp_q.pop_front() || observed !== expected) begin
      errors++;
      $display("[TB] FAIL priority got %h expected %h", observed, expected);
    end
  endtask

  task automatic test_stall_flush();
    out_t frozen;
    in_t  i;
    frozen = model_state;
    for (int c = 0; c < 2; c++) begin
      i = random_in();
      i.req = 1'b0;
      i.en  = 1'b0;
      drive_and_step(i);
      checks++;
      if (observed !== exp_q.pop_front() || observed !== frozen) begin
        errors++;
        $display("[TB] FAIL stall%0d got %h expected %h", c, observed, frozen);
      end
    end
    i = random_in();
    i.req = 1'b1;
    i.en  = 1'b0;
    drive_and_step(i);
    checks++;
    if (observed !== exp_q.pop_front() || observed !== BUB_OUT) begin
      errors++;
      $display("[TB] FAIL flush got %h expected %h", observed, BUB_OUT);
    end
  endtask

  task automatic test_async_reset();
    in_t i = '0;
    i.en = 1'b1; i.pc = 32'h3010; i.alu_out = 32'hABCD; i.a3 = 5'd9;
    i.reg_write = 1'b1; i.load = 1'b1;
    drive_and_step(i);
    void'(exp_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed !== RST_OUT) begin
      errors++;
      $display("[TB] FAIL async_reset got %h expected %h", observed, RST_OUT);
    end
    #1 rst_n = 1'b1;
    model_state = RST_OUT;
    i.pc = 32'h3014; i.a3 = 5'd0; i.load = 1'b0;
    drive_and_step(i);
    expected = '{32'h3014, 32'h0, 32'hABCD, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    checks++;
    if (observed !== exp_q.pop_front() || observed !== expected) begin
      errors++;
      $display("[TB] FAIL post_reset_load got %h expected %h", observed, expected);
    end
  endtask

  task automatic test_back_to_back();
    out_t want;
    for (int c = 0; c < 40; c++) begin
      drive_and_step(random_in());
      want = exp_q.pop_front();
      checks++;
      if (observed !== want) begin
        errors++;
        $display("[TB] FAIL back_to_back%0d got %h expected %h", c, observed, want);
      end
    end
  endtask

  initial begin
    model_state = RST_OUT;
    test_reset();
    test_normal_load();
    test_overflow();
    test_priority();
    test_stall_flush();
    test_async_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
